// File: rtl/usbfs_debug_pkg.sv
// usbfs_debug_pkg
//   Shared definitions for the USB full-speed debug-stream arbiter:
//   arbiter state encoding, the ASCII line terminator that ends a grant,
//   the drop-counter width and a saturating increment helper.
package usbfs_debug_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int         DROP_W   = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        if (v == {DROP_W{1'b1}}) begin
            return v;
        end
        return v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/usbfs_debug_arbiter_if.sv
// usbfs_debug_arbiter_if
//   Byte-stream bundle of the debug arbiter.
//   s0_en/s0_data, s1_en/s1_data : source byte strobes, no backpressure.
//   out_valid/out_data/out_ready : stream to the UART transmitter.
//   Handshake: a byte transfers on a rising clk edge where out_valid and
//   out_ready are both high; once out_valid is high, out_data holds its
//   value and out_valid stays high until that transfer happens.
//   master : the side that drives the sources and out_ready.
//   slave  : the arbiter.
interface usbfs_debug_arbiter_if;
    logic       s0_en;
    logic [7:0] s0_data;
    logic       s1_en;
    logic [7:0] s1_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output s0_en, s0_data, s1_en, s1_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  s0_en, s0_data, s1_en, s1_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/usbfs_debug_fifo.sv
// usbfs_debug_fifo
//   Synchronous first-word-fall-through byte FIFO.
//   clk, rstn       : clock, asynchronous active-low reset (empties FIFO).
//   push, push_data : write strobe and byte; caller only pushes when the
//                     FIFO is not full or a pop happens in the same cycle.
//   pop             : consume head; caller only pops when not empty.
//   full, empty     : status; head : current oldest byte.
module usbfs_debug_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/usbfs_debug_arbiter.sv
// usbfs_debug_arbiter
//   Merges two ASCII debug byte streams (USB monitor, application) onto one
//   UART TX stream. Each source owns a FIFO; the arbiter grants one source
//   at a time and holds the grant until a line feed is sent or the granted
//   FIFO has stayed empty for IDLE_TO cycles, so lines never interleave.
//   clk, rstn        : clock, asynchronous active-low reset.
//   bus              : source strobes and output handshake (slave side).
//   clr              : synchronous clear of ovf and drop counters.
//   ovf              : sticky overflow flag per source.
//   drop0, drop1     : saturating dropped-byte counters.
//   dbg_state        : current arbiter state.
module usbfs_debug_arbiter
    import usbfs_debug_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int IDLE_TO = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    usbfs_debug_arbiter_if.slave bus,
    input  logic                 clr,
    output logic [1:0]           ovf,
    output logic [DROP_W-1:0]    drop0,
    output logic [DROP_W-1:0]    drop1,
    output arb_state_t           dbg_state
);
    localparam logic [15:0] IDLE_LAST = 16'(IDLE_TO - 1);

    logic       full0, empty0, push0, pop0, drop_ev0;
    logic       full1, empty1, push1, pop1, drop_ev1;
    logic [7:0] head0, head1;

    arb_state_t  state, state_nxt;
    logic        rr_last, rr_nxt;      // source served last; 1 after reset
    logic [15:0] idle_cnt, idle_cnt_nxt;

    logic       granted, g_src, g_empty, pop;
    logic [7:0] g_head;

    assign granted = (state != ARB_IDLE);
    assign g_src   = (state == ARB_GRANT1);
    assign g_empty = g_src ? empty1 : empty0;
    assign g_head  = g_src ? head1 : head0;

    assign bus.out_valid = granted && !g_empty;
    assign bus.out_data  = bus.out_valid ? g_head : 8'h00;
    assign pop  = bus.out_valid && bus.out_ready;
    assign pop0 = pop && !g_src;
    assign pop1 = pop && g_src;

    // A full FIFO still takes a byte when its own head leaves this cycle.
    assign push0    = bus.s0_en && (!full0 || pop0);
    assign push1    = bus.s1_en && (!full1 || pop1);
    assign drop_ev0 = bus.s0_en && full0 && !pop0;
    assign drop_ev1 = bus.s1_en && full1 && !pop1;

    usbfs_debug_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rstn(rstn), .push(push0), .push_data(bus.s0_data),
        .pop(pop0), .full(full0), .empty(empty0), .head(head0)
    );

    usbfs_debug_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rstn(rstn), .push(push1), .push_data(bus.s1_data),
        .pop(pop1), .full(full1), .empty(empty1), .head(head1)
    );

    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_last;
        idle_cnt_nxt = idle_cnt;
        case (state)
            ARB_IDLE: begin
                idle_cnt_nxt = '0;
                if (!empty0 && !empty1) begin
                    state_nxt = rr_last ? ARB_GRANT0 : ARB_GRANT1;
                end else if (!empty0) begin
                    state_nxt = ARB_GRANT0;
                end else if (!empty1) begin
                    state_nxt = ARB_GRANT1;
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                if (pop && g_head == ASCII_LF) begin
                    state_nxt    = ARB_IDLE;
                    rr_nxt       = g_src;
                    idle_cnt_nxt = '0;
                end else if (g_empty) begin
                    // This cycle is the IDLE_TO-th empty one when the count
                    // already holds IDLE_TO-1.
                    if (idle_cnt == IDLE_LAST) begin
                        state_nxt    = ARB_IDLE;
                        idle_cnt_nxt = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 16'd1;
                    end
                end else begin
                    idle_cnt_nxt = '0;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ARB_IDLE;
            rr_last  <= 1'b1;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_last  <= rr_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // A drop coinciding with clr survives the clear as a single count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf   <= 2'b00;
            drop0 <= '0;
            drop1 <= '0;
        end else if (clr) begin
            ovf   <= {drop_ev1, drop_ev0};
            drop0 <= {{(DROP_W-1){1'b0}}, drop_ev0};
            drop1 <= {{(DROP_W-1){1'b0}}, drop_ev1};
        end else begin
            if (drop_ev0) begin
                ovf[0] <= 1'b1;
                drop0  <= sat_inc(drop0);
            end
            if (drop_ev1) begin
                ovf[1] <= 1'b1;
                drop1  <= sat_inc(drop1);
            end
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_usbfs_debug_arbiter.sv
// tb_usbfs_debug_arbiter
//   Bench for usbfs_debug_arbiter (DEPTH=4, IDLE_TO=8): directed scenarios
//   plus randomized traffic, all compared cycle by cycle against a
//   queue-based reference model of the arbitration rules.
module tb_usbfs_debug_arbiter;
    import usbfs_debug_pkg::*;

    localparam int DEPTH   = 4;
    localparam int IDLE_TO = 8;

    // ---------------- clock / reset ----------------
    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       clr  = 1'b0;
    logic [1:0] ovf;
    logic [7:0] drop0, drop1;
    arb_state_t dbg_state;

    usbfs_debug_arbiter_if ifc();

    usbfs_debug_arbiter #(.DEPTH(DEPTH), .IDLE_TO(IDLE_TO)) dut (
        .clk(clk), .rstn(rstn), .bus(ifc), .clr(clr),
        .ovf(ovf), .drop0(drop0), .drop1(drop1), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] out_log[$];
    int         log_cyc[$];

    // ---------------- reference model ----------------
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    int         m_owner;   // -1 none, else granted source
    int         m_last;    // source that finished a line last
    int         m_ecnt;    // consecutive empty cycles within a grant
    logic [1:0] m_ovf;
    int         m_drop0, m_drop1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        exp_q.delete(); got_q.delete();
        out_log.delete(); log_cyc.delete();
        m_owner = -1; m_last = 1; m_ecnt = 0;
        m_ovf = 2'b00; m_drop0 = 0; m_drop1 = 0;
    endtask

    // One clock edge of the arbitration rules, applied to queue sizes
    // as they stood before the edge.
    task automatic model_edge(input logic e0, input logic [7:0] d0,
                              input logic e1, input logic [7:0] d1,
                              input logic rdy, input logic c);
        int s0, s1, gsz;
        logic pop, acc0, acc1, dr0, dr1;
        logic [7:0] pb;
        s0 = mq0.size(); s1 = mq1.size(); pb = 8'h00;
        gsz = (m_owner == 0) ? s0 : (m_owner == 1) ? s1 : 0;
        pop = (gsz > 0) && rdy;
        if (pop) begin
            if (m_owner == 0) pb = mq0.pop_front();
            else              pb = mq1.pop_front();
            exp_q.push_back(pb);
        end
        acc0 = e0 && (s0 < DEPTH || (pop && m_owner == 0));
        acc1 = e1 && (s1 < DEPTH || (pop && m_owner == 1));
        dr0  = e0 && !acc0;
        dr1  = e1 && !acc1;
        if (acc0) mq0.push_back(d0);
        if (acc1) mq1.push_back(d1);
        if (c) begin
            m_ovf   = {dr1, dr0};
            m_drop0 = dr0 ? 1 : 0;
            m_drop1 = dr1 ? 1 : 0;
        end else begin
            if (dr0) begin m_ovf[0] = 1'b1; if (m_drop0 < 255) m_drop0++; end
            if (dr1) begin m_ovf[1] = 1'b1; if (m_drop1 < 255) m_drop1++; end
        end
        if (m_owner < 0) begin
            if (s0 > 0 && s1 > 0) m_owner = (m_last == 1) ? 0 : 1;
            else if (s0 > 0)      m_owner = 0;
            else if (s1 > 0)      m_owner = 1;
            m_ecnt = 0;
        end else if (pop && pb == 8'h0A) begin
            m_last  = m_owner;
            m_owner = -1;
            m_ecnt  = 0;
        end else if (gsz == 0) begin
            m_ecnt++;
            if (m_ecnt >= IDLE_TO) begin
                m_owner = -1;
                m_ecnt  = 0;
            end
        end else begin
            m_ecnt = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left at a falling edge: compare outputs, drive inputs,
    // take the rising edge, advance the model.
    task automatic step(input logic e0, input logic [7:0] d0,
                        input logic e1, input logic [7:0] d1,
                        input logic rdy, input logic c);
        logic       m_valid;
        logic [7:0] m_head;
        m_valid = 1'b0; m_head = 8'h00;
        if (m_owner == 0 && mq0.size() > 0) begin m_valid = 1'b1; m_head = mq0[0]; end
        if (m_owner == 1 && mq1.size() > 0) begin m_valid = 1'b1; m_head = mq1[0]; end
        check("out_valid", ifc.out_valid, m_valid);
        if (m_valid) check("out_data", ifc.out_data, m_head);
        check("ovf", ovf, m_ovf);
        check("drop0", drop0, m_drop0);
        check("drop1", drop1, m_drop1);
        ifc.s0_en = e0; ifc.s0_data = d0;
        ifc.s1_en = e1; ifc.s1_data = d1;
        ifc.out_ready = rdy;
        clr = c;
        if (ifc.out_valid && rdy) begin
            got_q.push_back(ifc.out_data);
            out_log.push_back(ifc.out_data);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_edge(e0, d0, e1, d1, rdy, c);
        cyc++;
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("stream", got_q.pop_front(), exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifc.s0_en = 1'b0; ifc.s0_data = 8'h00;
        ifc.s1_en = 1'b0; ifc.s1_data = 8'h00;
        ifc.out_ready = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", ifc.out_valid, 1'b0);
        check("rst_data", ifc.out_data, 8'h00);
        check("rst_ovf", ovf, 2'b00);
        check("rst_drop0", drop0, 8'h00);
        check("rst_drop1", drop1, 8'h00);
        check("rst_state", dbg_state, ARB_IDLE);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic send0(input string s, input logic rdy);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic send_both(input string a, input string b, input logic rdy);
        int n;
        n = (a.len() > b.len()) ? a.len() : b.len();
        for (int i = 0; i < n; i++)
            step(i < a.len(), (i < a.len()) ? a[i] : 8'h00,
                 i < b.len(), (i < b.len()) ? b[i] : 8'h00, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic check_log(input string tag, input string s);
        check({tag, "_len"}, out_log.size(), s.len());
        for (int i = 0; i < s.len() && i < out_log.size(); i++)
            check(tag, out_log[i], s[i]);
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 5) == 0) return 8'h0A;
        return 8'($urandom_range(32, 126));
    endfunction

    task automatic rand_phase(input int n, input int p_en, input int p_rdy, input int p_clr);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 99) < p_en, rand_byte(),
                 $urandom_range(0, 99) < p_en, rand_byte(),
                 $urandom_range(0, 99) < p_rdy,
                 $urandom_range(0, 999) < p_clr);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w;
        clear_inputs();
        #1;
        do_reset();

        // Single line on source 0; LF comes first, so the grant drops after it.
        w = cyc;
        send0("\n-> 01 ", 1'b1);
        idle(20, 1'b1);
        check_log("t035_bytes", "\n-> 01 ");
        if (log_cyc.size() >= 2) begin
            check("t035_latency", log_cyc[0] - w, 2);
            check("t035_lf_release", log_cyc[1] - log_cyc[0], 2);
        end

        // Simultaneous lines: source 0 wins the first tie, no interleaving.
        do_reset();
        send_both("AB\n", "AB\n", 1'b1);
        idle(12, 1'b1);
        check_log("t036_bytes", "AB\nAB\n");

        // Overflow of source 1 with the sink stalled, then clear.
        do_reset();
        send_both("", "abcdef", 1'b0);
        check("t037_ovf", ovf, 2'b10);
        check("t037_drop1", drop1, 8'd2);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        check("t037_clr_ovf", ovf, 2'b00);
        check("t037_clr_drop1", drop1, 8'd0);
        idle(20, 1'b1);
        check_log("t037_bytes", "abcd");

        // Write into a full FIFO in the same cycle as its head leaves.
        do_reset();
        send0("1234", 1'b0);
        step(1'b1, 8'h35, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t038_drop0", drop0, 8'd0);
        check("t038_ovf", ovf, 2'b00);
        idle(20, 1'b1);
        check_log("t038_bytes", "12345");

        // Unterminated line releases by timeout before the other source runs.
        do_reset();
        send_both("xy", "z\n", 1'b1);
        idle(30, 1'b1);
        check_log("t039_bytes", "xyz\n");
        if (log_cyc.size() >= 3)
            check("t039_gap", log_cyc[2] - log_cyc[1], IDLE_TO + 2);

        // Asynchronous reset with data buffered and out_valid high.
        do_reset();
        send_both("0123456789", "abcdefghij", 1'b0);
        check("t040_pre_valid", ifc.out_valid, 1'b1);
        clear_inputs();
        #2 rstn = 1'b0;
        #1;
        check("t040_rst_valid", ifc.out_valid, 1'b0);
        check("t040_rst_data", ifc.out_data, 8'h00);
        check("t040_rst_ovf", ovf, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        idle(6, 1'b1);
        check("t040_no_stale", out_log.size(), 0);
        send0("ok\n", 1'b1);
        idle(4, 1'b1);
        check_log("t040_new", "ok\n");

        // Randomized traffic, including a stall long enough to saturate.
        do_reset();
        rand_phase(1500, 40, 70, 5);
        rand_phase(300, 100, 0, 0);
        check("sat_drop0", drop0, 8'd255);
        check("sat_drop1", drop1, 8'd255);
        rand_phase(1000, 30, 90, 10);
        idle(40, 1'b1);
        check("sb_residual", exp_q.size() + got_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
